// File: rtl/memory_arbiter.sv
// Unified RAM port arbiter: shares one memory port between instruction fetch
// and data load/store, data first, with a streak limit so fetch cannot starve.
module memory_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int CNT_W       = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready
);

  typedef enum logic [2:0] {
    IDLE, IACC, DACC, IDONE, DDONE
  } state_t;

  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DSTREAK);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] streak_q, streak_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      store_q, store_d;
  logic [31:0]      iload_q, iload_d;
  logic [31:0]      dload_q, dload_d;
  logic             ren_q, ren_d;
  logic             wen_q, wen_d;
  logic             dreq;
  logic             take_data;

  assign dreq      = dREN | dWEN;
  assign take_data = dreq & ~(iREN & (streak_q == STREAK_MAX));

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    store_d  = store_q;
    iload_d  = iload_q;
    dload_d  = dload_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    unique case (state_q)
      IDLE: begin
        if (take_data) begin
          state_d = DACC;
          addr_d  = daddr;
          store_d = dstore;
          wen_d   = dWEN;
          ren_d   = ~dWEN;
          if (!iREN)
            streak_d = '0;
          else if (streak_q != STREAK_MAX)
            streak_d = streak_q + 1'b1;
        end else if (iREN) begin
          state_d  = IACC;
          addr_d   = iaddr;
          ren_d    = 1'b1;
          wen_d    = 1'b0;
          streak_d = '0;
        end
      end
      IACC: begin
        if (ramready) begin
          iload_d = ramload;
          ren_d   = 1'b0;
          state_d = IDONE;
        end
      end
      DACC: begin
        if (ramready) begin
          if (ren_q)
            dload_d = ramload;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          state_d = DDONE;
        end
      end
      IDONE, DDONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      streak_q <= '0;
      addr_q   <= '0;
      store_q  <= '0;
      iload_q  <= '0;
      dload_q  <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      iload_q  <= iload_d;
      dload_q  <= dload_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
    end
  end

  assign iwait    = iREN & (state_q != IDONE);
  assign dwait    = dreq & (state_q != DDONE);
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign ramREN   = ren_q;
  assign ramWEN   = wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: transaction-level reference model, a variable
// latency RAM, and directed scenarios with hand-computed expectations.
module tb_memory_arbiter;

  localparam int MAXD = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload;
  logic        ramready;

  memory_arbiter #(.MAX_DSTREAK(MAXD), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramready(ramready)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM with programmable latency
  logic [31:0] mem [logic [31:0]];
  int ram_lat  = 0;
  int wait_cnt = 0;
  int strobes  = 0;

  always @(posedge CLK) begin
    if (ramWEN && ramready) mem[ramaddr] = ramstore;
    if ((ramREN || ramWEN) && !ramready) wait_cnt++;
    else wait_cnt = 0;
  end

  always @(negedge CLK) begin
    ramready = (ramREN || ramWEN) && (wait_cnt >= ram_lat);
    ramload  = mem.exists(ramaddr) ? mem[ramaddr] : ~ramaddr;
  end

  // Reference model: a transaction is idle, in flight, or just finished
  typedef enum int {M_IDLE, M_BUSY, M_DONE} mphase_t;
  mphase_t     m_ph = M_IDLE;
  bit          m_data, m_wr;
  logic [31:0] m_addr, m_store, m_iload, m_dload;
  int          m_streak;
  int          grants[$];

  always @(posedge CLK) begin
    if (RST) begin
      m_ph = M_IDLE; m_data = 0; m_wr = 0; m_streak = 0;
      m_addr = 0; m_store = 0; m_iload = 0; m_dload = 0;
    end else if (m_ph == M_IDLE) begin
      if ((dREN || dWEN) && !(iREN && m_streak == MAXD)) begin
        m_ph = M_BUSY; m_data = 1; m_wr = dWEN;
        m_addr = daddr; m_store = dstore;
        m_streak = iREN ? ((m_streak + 1 > MAXD) ? MAXD : m_streak + 1) : 0;
        grants.push_back(1);
      end else if (iREN) begin
        m_ph = M_BUSY; m_data = 0; m_wr = 0;
        m_addr = iaddr; m_streak = 0;
        grants.push_back(2);
      end
    end else if (m_ph == M_BUSY) begin
      if (ramready) begin
        if (!m_wr) begin
          if (m_data) m_dload = ramload;
          else m_iload = ramload;
        end
        m_ph = M_DONE;
      end
    end else begin
      m_ph = M_IDLE;
    end
    if (RST) chk_en = 1;
  end

  always @(negedge CLK) begin
    if (ramREN || ramWEN) strobes++;
    if (chk_en) begin
      check("iwait", 32'(iwait), 32'(iREN && !(m_ph == M_DONE && !m_data)));
      check("dwait", 32'(dwait),
            32'((dREN || dWEN) && !(m_ph == M_DONE && m_data)));
      check("ramREN", 32'(ramREN), 32'(m_ph == M_BUSY && !m_wr));
      check("ramWEN", 32'(ramWEN), 32'(m_ph == M_BUSY && m_wr));
      check("ramaddr", ramaddr, m_addr);
      if (m_ph == M_BUSY && m_wr) check("ramstore", ramstore, m_store);
      check("iload", iload, m_iload);
      check("dload", dload, m_dload);
      check("streak", 32'(dut.streak_q), 32'(m_streak));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_low(input bit is_i, input string nm);
    bit ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (is_i ? !iwait : !dwait) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: wait still high after 40 cycles", nm);
    end
    step();
  endtask

  function automatic int gcode(input int from);
    int c = 0;
    for (int i = from; i < grants.size(); i++) c = c * 10 + grants[i];
    return c;
  endfunction

  int s0, g0;

  initial begin
    RST = 1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0;
    ramready = 0; ramload = 0;
    mem[32'h40] = 32'h8C220004;
    step(); step();
    RST = 0;
    @(negedge CLK);
    check("rst_ramREN", 32'(ramREN), 32'h0);
    check("rst_ramaddr", ramaddr, 32'h0);
    step();

    // fetch, zero latency
    ram_lat = 0; s0 = strobes;
    iREN = 1; iaddr = 32'h40;
    wait_low(1, "fetch");
    iREN = 0;
    check("fetch_iload", iload, 32'h8C220004);
    check("fetch_strobes", 32'(strobes - s0), 32'd1);
    step();

    // write, three strobe cycles
    ram_lat = 2; s0 = strobes;
    dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    wait_low(0, "write");
    dWEN = 0;
    check("write_strobes", 32'(strobes - s0), 32'd3);
    check("write_mem", mem[32'h100], 32'hDEADBEEF);
    step();

    // read back
    ram_lat = 1;
    dREN = 1; daddr = 32'h100;
    wait_low(0, "readback");
    dREN = 0;
    check("readback_dload", dload, 32'hDEADBEEF);
    step();

    // simultaneous: data first, then fetch
    ram_lat = 0; g0 = grants.size();
    iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h200;
    wait_low(0, "simul_d");
    dREN = 0;
    wait_low(1, "simul_i");
    iREN = 0;
    check("simul_order", 32'(gcode(g0)), 32'd12);
    check("simul_dload", dload, ~32'h200);
    step();

    // starvation limit
    g0 = grants.size();
    iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h300;
    wait_low(1, "starve");
    iREN = 0; dREN = 0;
    check("starve_order", 32'(gcode(g0)), 32'd11112);
    check("starve_streak", 32'(dut.streak_q), 32'd0);
    step();

    // reset during a long data access
    ram_lat = 5;
    dREN = 1; daddr = 32'h100;
    step(); step();
    RST = 1;
    step();
    RST = 0; dREN = 0;
    @(negedge CLK);
    check("rstmid_ramREN", 32'(ramREN), 32'h0);
    check("rstmid_dload", dload, 32'h0);
    step();
    ram_lat = 1;
    dWEN = 1; daddr = 32'h104; dstore = 32'h12345678;
    wait_low(0, "post_rst");
    dWEN = 0;
    check("post_rst_mem", mem[32'h104], 32'h12345678);
    step();

    // requester drops mid-access
    ram_lat = 3; g0 = grants.size(); s0 = strobes;
    dREN = 1; daddr = 32'h100;
    step();
    dREN = 0;
    repeat (8) step();
    check("drop_grants", 32'(gcode(g0)), 32'd1);
    check("drop_strobes", 32'(strobes - s0), 32'd4);
    check("drop_dload", dload, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
